simple_widthadapt_x_to_1: RTL and testbench

Wide-to-narrow width adapter: accepts one `p_iwidth*p_x`-bit word per valid/ready transfer and emits it as `p_x` consecutive `p_iwidth`-bit words. It is the downstream counterpart of `simple_widthadapt_1_to_x`, unpacking the wide words that block produces (for example, packed frame-buffer words back into pixels for the display path). There are no bubbles between consecutive wide words when both sides stream.

---
 rtl/simple_widthadapt_x_to_1.sv | 91 +++++++++
 tb/tb_simple_widthadapt_x_to_1.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/simple_widthadapt_x_to_1.sv
// Wide-to-narrow width adapter: unpacks one p_iwidth*p_x word into p_x narrow words.
// Define WIDTHADAPT_X_TO_1_MSB_FIRST_EN to emit the highest lane first.
module simple_widthadapt_x_to_1 #(
    parameter int p_iwidth = 16,
    parameter int p_x      = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_valid,
    input  logic [p_iwidth*p_x-1:0]      i_data,
    output logic                         o_ready,
    output logic                         o_valid,
    output logic [p_iwidth-1:0]          o_data,
    output logic                         o_last,
    input  logic                         i_ready
);

    localparam int p_wwidth = p_iwidth * p_x;
    localparam int p_xw     = $clog2(p_x);
    localparam logic [p_xw-1:0] LP_LAST = p_xw'(p_x - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              r_state_reg, w_state_next;
    logic [p_xw-1:0]     r_cnt_reg, w_cnt_next;
    logic [p_wwidth-1:0] r_hold_reg, w_hold_next;

    logic                w_up;
    logic                w_dn;
    logic                w_is_last;
    logic [p_xw-1:0]     w_lane;
    logic [p_iwidth-1:0] w_lanes [p_x];

    genvar gi;
    generate
        for (gi = 0; gi < p_x; gi++) begin : g_lane
            assign w_lanes[gi] = r_hold_reg[gi*p_iwidth +: p_iwidth];
        end
    endgenerate

    // Lane selection is the only difference between the two emission orders.
`ifdef WIDTHADAPT_X_TO_1_MSB_FIRST_EN
    assign w_lane = LP_LAST - r_cnt_reg;
`else
    assign w_lane = r_cnt_reg;
`endif

    assign w_is_last = (r_cnt_reg == LP_LAST);
    assign o_valid   = (r_state_reg == SHIFT);
    assign o_ready   = i_rst_n && ((r_state_reg == IDLE) || (w_is_last && i_ready));
    assign o_last    = o_valid && w_is_last;
    assign o_data    = w_lanes[w_lane];
    assign w_up      = i_valid && o_ready;
    assign w_dn      = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state_reg <= IDLE;
            r_cnt_reg   <= '0;
            r_hold_reg  <= '0;
        end else begin
            r_state_reg <= w_state_next;
            r_cnt_reg   <= w_cnt_next;
            r_hold_reg  <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next = r_state_reg;
        w_cnt_next   = r_cnt_reg;
        w_hold_next  = r_hold_reg;
        if (w_dn) begin
            if (!w_is_last) begin
                w_cnt_next = r_cnt_reg + 1'b1;
            end else begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        end
        // A load on the last-lane beat overrides the return to IDLE.
        if (w_up) begin
            w_hold_next  = i_data;
            w_cnt_next   = '0;
            w_state_next = SHIFT;
        end
    end

endmodule

// File: tb/tb_simple_widthadapt_x_to_1.sv
// Directed testbench for simple_widthadapt_x_to_1 (p_iwidth=16, p_x=8).
// Expected lane order follows WIDTHADAPT_X_TO_1_MSB_FIRST_EN when defined.
module tb_simple_widthadapt_x_to_1;

    localparam int W = 16;
    localparam int X = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic [W*X-1:0]   i_data;
    logic             o_ready;
    logic             o_valid;
    logic [W-1:0]     o_data;
    logic             o_last;
    logic             i_ready;

    int checks   = 0;
    int failures = 0;

    simple_widthadapt_x_to_1 #(.p_iwidth(W), .p_x(X)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    // w < 0 selects the 16'h1111*k pattern; otherwise lane k of word w is {w, k}.
    function automatic logic [W-1:0] lane_val(input int w, input int k);
        if (w < 0) return 16'(32'h1111 * k);
        return {8'(w), 8'(k)};
    endfunction

    function automatic logic [W*X-1:0] wide(input int w);
        logic [W*X-1:0] v;
        v = '0;
        for (int k = 0; k < X; k++) v[k*W +: W] = lane_val(w, k);
        return v;
    endfunction

    function automatic logic [W-1:0] emit(input int w, input int j);
`ifdef WIDTHADAPT_X_TO_1_MSB_FIRST_EN
        return lane_val(w, X - 1 - j);
`else
        return lane_val(w, j);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
        chk({tag, "_data"},  {16'd0, o_data}, {16'd0, d});
        chk({tag, "_last"},  {31'd0, o_last}, {31'd0, l});
    endtask

    initial begin
        int j;
        int c;
        logic [3:0] bp_pat;
        bp_pat = 4'b1001;

        // Reset with upstream offering a word.
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_data  = wide(9);
        i_ready = 1'b1;
        for (int n = 0; n < 4; n++) step();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_last",  {31'd0, o_last},  32'd0);
        chk("rst_data",  {16'd0, o_data},  32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd0);

        // Single word, sink always ready.
        i_valid = 1'b1;
        i_data  = wide(-1);
        step();
        i_valid = 1'b0;
        i_data  = '0;
        for (int k = 0; k < X; k++) begin
            chk_out($sformatf("single%0d", k), emit(-1, k), k == X - 1);
            step();
        end
        chk("single_end", {31'd0, o_valid}, 32'd0);

        // Streaming four words back-to-back.
        i_valid = 1'b1;
        i_data  = wide(0);
        step();
        for (int t = 0; t < 4 * X; t++) begin
            i_data  = wide(t / X + 1);
            i_valid = (t < 4 * X - 1);
            chk_out($sformatf("strm%0d", t), emit(t / X, t % X), (t % X) == X - 1);
            chk($sformatf("strm%0d_rdy", t), {31'd0, o_ready}, {31'd0, (t % X) == X - 1});
            step();
        end
        i_valid = 1'b0;
        chk("strm_end", {31'd0, o_valid}, 32'd0);

        // Backpressure with ready pattern 1,0,0,1.
        i_valid = 1'b1;
        i_data  = wide(5);
        step();
        i_valid = 1'b0;
        j = 0;
        c = 0;
        while (j < X && c < 64) begin
            i_ready = bp_pat[3 - (c % 4)];
            #1;
            chk_out($sformatf("bp_c%0d", c), emit(5, j), j == X - 1);
            chk($sformatf("bp_c%0d_rdy", c), {31'd0, o_ready}, {31'd0, (j == X - 1) && i_ready});
            step();
            if (i_ready) j++;
            c++;
        end
        chk("bp_lanes_done", j, X);
        i_ready = 1'b1;
        #1;
        chk("bp_end", {31'd0, o_valid}, 32'd0);

        // Reset after lane 3 has been accepted.
        i_valid = 1'b1;
        i_data  = wide(7);
        step();
        i_valid = 1'b0;
        for (int n = 0; n < 4; n++) step();
        chk_out("mid_lane4", emit(7, 4), 1'b0);
        i_rst_n = 1'b0;
        step();
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_data",  {16'd0, o_data},  32'd0);
        i_rst_n = 1'b1;
        step();
        chk("mid_post_valid", {31'd0, o_valid}, 32'd0);
        i_valid = 1'b1;
        i_data  = wide(3);
        step();
        i_valid = 1'b0;
        for (int k = 0; k < X; k++) begin
            chk_out($sformatf("after%0d", k), emit(3, k), k == X - 1);
            step();
        end
        chk("after_end", {31'd0, o_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
